// File: rtl/bus_master.sv
// CPU-side bus master: takes one load/store from the core at a time, runs it on the
// shared system bus and returns read data, or an error when no slave answers in time.
module bus_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] BUS_addr,
  output logic [DATA_WIDTH-1:0] BUS_wdata,
  output logic                  BUS_mode,
  output logic                  BUS_valid,
  input  logic                  BUS_wready,
  input  logic                  BUS_rvalid,
  input  logic [DATA_WIDTH-1:0] BUS_rdata,
  output logic                  BUS_rready,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e                  state_q;
  logic [15:0]             cnt_q;
  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic [DATA_WIDTH-1:0]   bus_wdata_q;
  logic                    bus_mode_q;
  logic                    bus_valid_q;
  logic                    resp_valid_q;
  logic                    resp_err_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;

  // Handshakes: a core request transfers on a posedge where req_valid & req_ready;
  // a bus transfer completes on the posedge where the slave's BUS_wready (write) or
  // BUS_rvalid (read) is sampled high while BUS_valid is held; BUS_rready only echoes
  // BUS_rvalid during a read so the slave never sees it early.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_mode_q   <= 1'b0;
      bus_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            bus_addr_q  <= req_addr;
            bus_wdata_q <= req_wdata;
            bus_mode_q  <= req_we;
            bus_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= req_we ? S_WR : S_RD;
          end
        end
        S_WR: begin
          if (BUS_wready) begin
            bus_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            bus_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RD: begin
          // A response arriving on the last counter value still wins over the timeout.
          if (BUS_rvalid) begin
            bus_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= BUS_rdata;
            state_q      <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            bus_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign BUS_rready = (state_q == S_RD) & BUS_rvalid;
  assign BUS_addr   = bus_addr_q;
  assign BUS_wdata  = bus_wdata_q;
  assign BUS_mode   = bus_mode_q;
  assign BUS_valid  = bus_valid_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign dbg_state  = state_q;

endmodule
